// File: rtl/ved_prod_accum.sv
// Frame accumulator behind the 64x64 Vedic multiplier: sums a framed stream of
// products and hands one registered sum per frame downstream over valid/ready.
module ved_prod_accum #(
    parameter int PROD_W    = 128,
    parameter int ACC_W     = 136,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] LP_MAX_CNT = CNT_W'(MAX_TERMS);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [ACC_W-1:0] r_outAcc;
    logic [CNT_W-1:0] r_outCount;
    logic             r_outOvf;
    logic             r_outValid;

    logic             w_accept;
    logic             w_pop;
    logic             w_frameEnd;
    logic [ACC_W:0]   w_sum;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_ovfNext;

    // Ready is combinational so a new beat can land in the same cycle as a pop.
    assign in_ready   = !rst && (!r_outValid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_pop      = r_outValid && out_ready;
    assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(in_prod);
    assign w_cntNext  = r_cnt + 1'b1;
    assign w_ovfNext  = r_ovf | w_sum[ACC_W];
    assign w_frameEnd = w_accept && (in_last || (w_cntNext == LP_MAX_CNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_outAcc   <= '0;
            r_outCount <= '0;
            r_outOvf   <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            if (w_frameEnd) begin
                r_outAcc   <= w_sum[ACC_W-1:0];
                r_outCount <= w_cntNext;
                r_outOvf   <= w_ovfNext;
                r_outValid <= 1'b1;
                r_acc      <= '0;
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_acc <= w_sum[ACC_W-1:0];
                    r_cnt <= w_cntNext;
                    r_ovf <= w_ovfNext;
                end
                // Popped without a replacement frame: data registers keep their value.
                if (w_pop) begin
                    r_outValid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_acc   = r_outAcc;
    assign out_count = r_outCount;
    assign out_ovf   = r_outOvf;

endmodule

// File: tb/tb_ved_prod_accum.sv
// Scoreboard bench for ved_prod_accum: directed frames plus random streams with
// random output stalls, checked against an exact-integer frame-sum model.
module tb_ved_prod_accum;

    localparam int PROD_W    = 128;
    localparam int ACC_W     = 129;
    localparam int MAX_TERMS = 4;
    localparam int CNT_W     = $clog2(MAX_TERMS + 1);

    typedef struct {
        logic [255:0] acc;
        int           cnt;
        logic         ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              inValid = 1'b0;
    logic              inReady;
    logic [PROD_W-1:0] inProd = '0;
    logic              inLast = 1'b0;
    logic              outValid;
    logic              outReady = 1'b0;
    logic [ACC_W-1:0]  outAcc;
    logic [CNT_W-1:0]  outCount;
    logic              outOvf;

    int checkCount = 0;
    int passCount  = 0;

    exp_t         expQ[$];
    logic         mOutValid = 1'b0;
    logic [255:0] frameTotal = '0;
    int           frameN = 0;
    logic         monitorOn = 1'b0;

    ved_prod_accum #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady), .in_prod(inProd), .in_last(inLast),
        .out_valid(outValid), .out_ready(outReady),
        .out_acc(outAcc), .out_count(outCount), .out_ovf(outOvf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock cycle: drive at posedge+1, check ready, then advance the model at the edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [PROD_W-1:0] p,
                                 input logic l, input logic ordy);
        logic expReady;
        logic pop;
        logic frameEnd;
        exp_t e;
        rst = r; inValid = v; inProd = p; inLast = l; outReady = ordy;
        expReady = !r && (!mOutValid || ordy);
        #1;
        checkOutput("in_ready", 256'(inReady), 256'(expReady));
        @(posedge clk);
        pop = mOutValid && ordy;
        frameEnd = 1'b0;
        if (r) begin
            mOutValid = 1'b0;
            frameTotal = '0;
            frameN = 0;
            expQ.delete();
        end else begin
            if (v && expReady) begin
                frameTotal += 256'(p);
                frameN++;
                if (l || frameN == MAX_TERMS) begin
                    e.acc = frameTotal % (256'(1) << ACC_W);
                    e.cnt = frameN;
                    e.ovf = (frameTotal >> ACC_W) != 0;
                    expQ.push_back(e);
                    frameTotal = '0;
                    frameN = 0;
                    mOutValid = 1'b1;
                    frameEnd = 1'b1;
                end
            end
            if (pop && !frameEnd) mOutValid = 1'b0;
        end
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("rst_out_valid", 256'(outValid), 256'(0));
        checkOutput("rst_out_acc",   256'(outAcc),   256'(0));
        checkOutput("rst_out_count", 256'(outCount), 256'(0));
        checkOutput("rst_out_ovf",   256'(outOvf),   256'(0));
        rst = 1'b0;
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on each handshake and
    // verifies that stalled outputs stay frozen.
    initial begin
        logic             held;
        logic [ACC_W-1:0] hAcc;
        logic [CNT_W-1:0] hCnt;
        logic             hOvf;
        exp_t             e;
        held = 1'b0;
        hAcc = '0; hCnt = '0; hOvf = 1'b0;
        forever begin
            @(negedge clk);
            if (monitorOn) begin
                checkOutput("out_valid", 256'(outValid), 256'(mOutValid));
                if (held && outValid) begin
                    checkOutput("stall_acc",   256'(outAcc),   256'(hAcc));
                    checkOutput("stall_count", 256'(outCount), 256'(hCnt));
                    checkOutput("stall_ovf",   256'(outOvf),   256'(hOvf));
                end
                held = outValid && !outReady;
                hAcc = outAcc; hCnt = outCount; hOvf = outOvf;
                if (outValid && outReady) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_output", 256'(1), 256'(0));
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("out_acc",   256'(outAcc),   e.acc);
                        checkOutput("out_count", 256'(outCount), 256'(e.cnt));
                        checkOutput("out_ovf",   256'(outOvf),   256'(e.ovf));
                    end
                end
            end
        end
    end

    initial begin
        logic [PROD_W-1:0] ones;
        logic [PROD_W-1:0] p;
        ones = '1;
        @(posedge clk);
        #1;
        doReset();
        monitorOn = 1'b1;

        // Basic three-term frame.
        applyStimulus(1'b0, 1'b1, 128'd6, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 128'd35, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 128'd1 << 127, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Overflow frames followed by a clean frame.
        applyStimulus(1'b0, 1'b1, ones, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, ones, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, ones, (i == 2), 1'b1);
        applyStimulus(1'b0, 1'b1, 128'd1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Forced flush at MAX_TERMS, then a short closing frame.
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 128'd1, (i == 5), 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Backpressure: hold the sum, offer ignored beats, then pop with a new frame.
        applyStimulus(1'b0, 1'b1, 128'd5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 128'd77, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 128'd9, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Reset in the middle of a frame discards the partial sum.
        applyStimulus(1'b0, 1'b1, 128'd5, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 128'd7, 1'b0, 1'b1);
        doReset();
        applyStimulus(1'b0, 1'b1, 128'd3, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Random streams with random stalls.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) p = ones - 128'($urandom_range(7));
            else p = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'b0, ($urandom_range(9) < 7), p,
                          ($urandom_range(9) < 3), ($urandom_range(9) < 7));
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("scoreboard_empty", 256'(expQ.size()), 256'(0));

        monitorOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ved_prod_accum.md
# ved_prod_accum

Downstream consumer of the 64x64 Vedic multiplier's 128-bit `result`. It accumulates a framed stream of products into a wide accumulator and hands one sum per frame to the next stage through a valid/ready register. A frame ends on `in_last` or when `MAX_TERMS` products have been accepted. This block turns the multiplier into a dot-product / MAC datapath.

## Interface
- `PROD_W`, 128: product width; matches multiplier `result` width.
- `ACC_W`, 136: accumulator width; must be ≥ `PROD_W`. The default is overflow-free for `MAX_TERMS`=256.
- `MAX_TERMS`, 256: maximum products per frame; must be ≥ 1.
- `CNT_W`, $clog2(`MAX_TERMS`+1): width of `out_count`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  `in_prod` holds a product. It is the operand-valid delayed one cycle, aligned with the multiplier's 1-cycle latency.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_prod`  in  `PROD_W`  unsigned product.
- `in_last`  in  1  this beat closes the frame.
- `out_valid`  out  1  frame sum available.
- `out_ready`  in  1  downstream takes the sum.
- `out_acc`  out  `ACC_W`  frame sum, modulo 2^`ACC_W`.
- `out_count`  out  `CNT_W`  number of products in the frame (1..`MAX_TERMS`).
- `out_ovf`  out  1  at least one accumulation carry was lost in this frame.

## Operation
- Internal state: `acc` (`ACC_W`), `cnt` (`CNT_W`), `ovf` (1), plus output registers `out_acc`, `out_count`, `out_ovf` and `out_valid`.
- Beat accepted when `in_valid && in_ready`.
- `in_ready = !rst && (!out_valid || out_ready)`. It is combinational: a new beat is accepted in the same cycle as an output pop.
- Accept, frame not ending:
  - `sum = {1'b0,acc} + zero-extended in_prod` (`ACC_W`+1 bits).
  - `acc <= sum[ACC_W-1:0]`, `cnt <= cnt+1`, `ovf <= ovf | sum[ACC_W]`.
- Frame end is an accepted beat with `in_last` or `cnt+1 == MAX_TERMS`. On frame end:
  - `out_acc <= sum[ACC_W-1:0]`, `out_count <= cnt+1`, `out_ovf <= ovf | sum[ACC_W]`, `out_valid <= 1`.
  - `acc`, `cnt` and `ovf` clear to 0.
- Pop (`out_valid && out_ready`) with no frame end in the same cycle: `out_valid <= 0`. Output data registers hold their value.
- Pop plus frame end in the same cycle: output registers reload with the new frame and `out_valid` stays 1.
- While `out_valid && !out_ready`: `in_ready` = 0, and the output and accumulator are frozen.
- Forced flush at `MAX_TERMS` ignores `in_last`. The next beat starts a new frame.
- `in_last` with `cnt`=0 yields a single-term frame: `out_count`=1, `out_acc`=`in_prod`.
- Beats with `in_valid` low, or offered while `in_ready` low, have no effect. The producer must hold or stall; the multiplier has no stall, so the wrapper gates operand issue on `in_ready`.
- Input X/Z is never registered when `in_valid`=0.

## Timing
- Reset (`rst` high at a rising edge): `out_valid`=0, `out_acc`=0, `out_count`=0, `out_ovf`=0, `acc`=0, `cnt`=0, `ovf`=0.
- `in_ready` = 0 while `rst` is high. A partial frame in progress is discarded, and a pending output is dropped.
- Latency: frame-ending beat accepted at edge N gives `out_valid`=1 with data visible after edge N (cycle N+1).
- End-to-end latency from operands at the multiplier is 2 cycles.
- Throughput: one product per cycle sustained when `out_ready`=1, including back-to-back single-term frames. No bubbles.
- `out_acc`, `out_count` and `out_ovf` are stable while `out_valid && !out_ready`.
- `out_valid` never deasserts without a pop or reset.
- All outputs are registered except `in_ready`.

## Test plan
- Frame `in_prod` = 6, 35, 2^127 with `in_last` on beat 3, `out_ready`=1:
  - `out_valid` pulses 1 cycle after beat 3, `out_acc`=2^127+41, `out_count`=3, `out_ovf`=0.
- Overflow, with an instance at `ACC_W`=129: beats 2^128−1 and 2^128−1 with last:
  - `out_acc`=2^129−2, `out_ovf`=0.
  - A second frame of 2^128−1 ×3 gives `out_acc`=(3·(2^128−1)) mod 2^129 and `out_ovf`=1.
  - The following frame shows `out_ovf`=0.
- Forced flush, `MAX_TERMS`=4: 6 beats of value 1, no `in_last`:
  - First output `out_acc`=4, `out_count`=4.
  - Then `in_last` on beat 6 gives `out_acc`=2, `out_count`=2.
- Backpressure: hold `out_ready`=0 for 5 cycles after a frame completes:
  - `in_ready`=0 and the output is stable throughout.
  - Raising `out_ready` together with a valid `in_last` beat of 9 pops the old sum, and the next cycle shows `out_acc`=9 with `out_valid` continuously 1.
- Reset mid-frame: accept 5 and 7 with no last, assert `rst` for 1 cycle, then send 3 with last:
  - `out_acc`=3, `out_count`=1.
  - All outputs are 0 during the cycle after reset.
- Random streams against a reference sum model, with random `out_ready` stalls:
  - Every frame sum, count and ovf matches the model.
  - No beat is lost or duplicated.
